// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB plus 2-bit saturating BHT,
// trained from resolved EX branches, with branch/mispredict statistics.
module branch_predictor #(
  parameter int BTB_IDX_BITS = 6,
  parameter int BHT_IDX_BITS = 8,
  parameter bit USE_BHT      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_IF,
  output logic        predict_br_IF,
  output logic        BHT_predict_IF,
  output logic [31:0] predict_target_IF,
  input  logic        update_en,
  input  logic [31:0] PC_EX,
  input  logic        br_taken_EX,
  input  logic [31:0] br_target_EX,
  input  logic        mispredict_EX,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);
  localparam int BTB_N = 1 << BTB_IDX_BITS;
  localparam int BHT_N = 1 << BHT_IDX_BITS;
  localparam int TAG_W = 30 - BTB_IDX_BITS;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } btb_entry_t;

  btb_entry_t [BTB_N-1:0]      btb_q, btb_d;
  logic [BHT_N-1:0][1:0]       bht_q, bht_d;
  logic [31:0]                 br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [BTB_IDX_BITS-1:0] if_btb_idx, ex_btb_idx;
  logic [BHT_IDX_BITS-1:0] if_bht_idx, ex_bht_idx;
  logic [TAG_W-1:0]        if_tag, ex_tag;
  logic                    btb_hit;
  btb_entry_t              if_ent;
  logic                    unused_pc;

  assign if_btb_idx = PC_IF[BTB_IDX_BITS+1:2];
  assign ex_btb_idx = PC_EX[BTB_IDX_BITS+1:2];
  assign if_bht_idx = PC_IF[BHT_IDX_BITS+1:2];
  assign ex_bht_idx = PC_EX[BHT_IDX_BITS+1:2];
  assign if_tag     = PC_IF[31:BTB_IDX_BITS+2];
  assign ex_tag     = PC_EX[31:BTB_IDX_BITS+2];
  assign unused_pc  = ^{PC_IF[1:0], PC_EX[1:0]};

  // Lookup reads the registered tables, so a same-cycle update is not visible yet.
  always_comb begin
    if_ent            = btb_q[if_btb_idx];
    btb_hit           = if_ent.valid && (if_ent.tag == if_tag);
    BHT_predict_IF    = bht_q[if_bht_idx][1];
    predict_br_IF     = btb_hit && (USE_BHT ? bht_q[if_bht_idx][1] : 1'b1);
    predict_target_IF = btb_hit ? if_ent.target : 32'h0;
  end

  always_comb begin
    btb_d      = btb_q;
    bht_d      = bht_q;
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (update_en) begin
      if (br_taken_EX) begin
        if (bht_q[ex_bht_idx] != 2'b11) bht_d[ex_bht_idx] = bht_q[ex_bht_idx] + 2'd1;
        btb_d[ex_btb_idx].valid  = 1'b1;
        btb_d[ex_btb_idx].tag    = ex_tag;
        btb_d[ex_btb_idx].target = br_target_EX;
      end else begin
        if (bht_q[ex_bht_idx] != 2'b00) bht_d[ex_bht_idx] = bht_q[ex_bht_idx] - 2'd1;
      end
      br_cnt_d = br_cnt_q + 32'd1;
      if (mispredict_EX) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_q      <= '0;
      bht_q      <= {BHT_N{2'b01}};
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      btb_q      <= btb_d;
      bht_q      <= bht_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign br_cnt   = br_cnt_q;
  assign miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench: a behavioural predictor model checked every cycle against two DUTs
// (BHT-gated and BTB-only), plus literal expectations from hand-worked cases.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst, update_en, br_taken_EX, mispredict_EX;
  logic [31:0] PC_IF, PC_EX, br_target_EX;
  logic        pred1, bhtp1, pred0, bhtp0;
  logic [31:0] tgt1, tgt0, brc1, brc0, miss1, miss0;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // model state: 64 BTB slots keyed by PC word index mod 64, 256 counters 0..3
  bit          m_valid [64];
  bit [31:0]   m_tag   [64];
  bit [31:0]   m_tgt   [64];
  int          m_ctr   [256];
  bit [31:0]   m_br, m_miss;

  always #5 clk = ~clk;

  branch_predictor #(.BTB_IDX_BITS(6), .BHT_IDX_BITS(8), .USE_BHT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .PC_IF(PC_IF), .predict_br_IF(pred1), .BHT_predict_IF(bhtp1),
    .predict_target_IF(tgt1), .update_en(update_en), .PC_EX(PC_EX), .br_taken_EX(br_taken_EX),
    .br_target_EX(br_target_EX), .mispredict_EX(mispredict_EX), .br_cnt(brc1), .miss_cnt(miss1));

  branch_predictor #(.BTB_IDX_BITS(6), .BHT_IDX_BITS(8), .USE_BHT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .PC_IF(PC_IF), .predict_br_IF(pred0), .BHT_predict_IF(bhtp0),
    .predict_target_IF(tgt0), .update_en(update_en), .PC_EX(PC_EX), .br_taken_EX(br_taken_EX),
    .br_target_EX(br_target_EX), .mispredict_EX(mispredict_EX), .br_cnt(brc0), .miss_cnt(miss0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; end
    for (int i = 0; i < 256; i++) m_ctr[i] = 1;
    m_br = 0; m_miss = 0;
  endfunction

  always @(posedge clk) begin
    if (rst) model_reset();
    else if (update_en) begin
      int bi, ti;
      bi = int'((PC_EX >> 2) % 256);
      ti = int'((PC_EX >> 2) % 64);
      if (br_taken_EX) begin
        m_ctr[bi] = (m_ctr[bi] + 1 > 3) ? 3 : m_ctr[bi] + 1;
        m_valid[ti] = 1; m_tag[ti] = PC_EX >> 8; m_tgt[ti] = br_target_EX;
      end else begin
        m_ctr[bi] = (m_ctr[bi] - 1 < 0) ? 0 : m_ctr[bi] - 1;
      end
      m_br = m_br + 1;
      if (mispredict_EX) m_miss = m_miss + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int bi, ti;
      bit hit, taken;
      bi = int'((PC_IF >> 2) % 256);
      ti = int'((PC_IF >> 2) % 64);
      hit = m_valid[ti] && (m_tag[ti] == (PC_IF >> 8));
      taken = (m_ctr[bi] >= 2);
      chk("pred", {31'd0, pred1}, {31'd0, hit && taken});
      chk("bhtp", {31'd0, bhtp1}, {31'd0, taken});
      chk("target", tgt1, hit ? m_tgt[ti] : 32'h0);
      chk("br_cnt", brc1, m_br);
      chk("miss_cnt", miss1, m_miss);
      chk("pred_nobht", {31'd0, pred0}, {31'd0, hit});
      chk("target_nobht", tgt0, hit ? m_tgt[ti] : 32'h0);
    end
  end

  task automatic cyc(input logic r, input logic ue, input logic [31:0] pcif, input logic [31:0] pcex,
                     input logic tk, input logic [31:0] tg, input logic mp);
    @(posedge clk); #1;
    rst = r; update_en = ue; PC_IF = pcif; PC_EX = pcex;
    br_taken_EX = tk; br_target_EX = tg; mispredict_EX = mp;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; update_en = 0; PC_IF = 32'h40; PC_EX = 0; br_taken_EX = 0; br_target_EX = 0; mispredict_EX = 0;
    model_reset();
    cyc(1, 0, 32'h40, 0, 0, 0, 0);
    cyc(1, 0, 32'h40, 0, 0, 0, 0);
    chk_on = 1'b1;
    cyc(0, 0, 32'h40, 0, 0, 0, 0);
    chk("L_rst_pred", {31'd0, pred1}, 32'd0);
    chk("L_rst_bhtp", {31'd0, bhtp1}, 32'd0);
    chk("L_rst_tgt", tgt1, 32'h0);
    chk("L_rst_brcnt", brc1, 32'd0);
    // taken at 0x40; lookup in the same cycle still sees the old state
    cyc(0, 1, 32'h40, 32'h40, 1, 32'h100, 0);
    chk("L_rdw_pred", {31'd0, pred1}, 32'd0);
    cyc(0, 0, 32'h40, 0, 0, 0, 0);
    chk("L_tk_pred", {31'd0, pred1}, 32'd1);
    chk("L_tk_bhtp", {31'd0, bhtp1}, 32'd1);
    chk("L_tk_tgt", tgt1, 32'h100);
    chk("L_tk_brcnt", brc1, 32'd1);
    repeat (4) cyc(0, 1, 32'h40, 32'h40, 0, 0, 0);
    cyc(0, 0, 32'h40, 0, 0, 0, 0);
    chk("L_nt_pred", {31'd0, pred1}, 32'd0);
    chk("L_nt_bhtp", {31'd0, bhtp1}, 32'd0);
    chk("L_nt_tgt", tgt1, 32'h100);
    chk("L_nt_pred_nobht", {31'd0, pred0}, 32'd1);
    cyc(0, 1, 32'h0, 32'h140, 1, 32'h200, 0);
    cyc(0, 0, 32'h40, 0, 0, 0, 0);
    chk("L_alias_miss_tgt", tgt1, 32'h0);
    chk("L_alias_miss_pred", {31'd0, pred1}, 32'd0);
    cyc(0, 0, 32'h140, 0, 0, 0, 0);
    chk("L_alias_hit_tgt", tgt1, 32'h200);
    chk("L_alias_hit_pred", {31'd0, pred1}, 32'd1);
    cyc(0, 1, 32'h80, 32'h80, 1, 32'h300, 0);
    chk("L_80_same", {31'd0, pred1}, 32'd0);
    cyc(0, 0, 32'h80, 0, 0, 0, 0);
    chk("L_80_next", {31'd0, pred1}, 32'd1);
    // reset wins over a coincident update
    cyc(1, 1, 32'h40, 32'h40, 1, 32'h400, 0);
    cyc(0, 0, 32'h40, 0, 0, 0, 0);
    chk("L_rstupd_tgt", tgt1, 32'h0);
    chk("L_rstupd_pred", {31'd0, pred1}, 32'd0);
    chk("L_rstupd_brcnt", brc1, 32'd0);
    cyc(0, 1, 32'h0, 32'h44, 0, 0, 1);
    cyc(0, 1, 32'h0, 32'h48, 1, 32'h500, 0);
    cyc(0, 1, 32'h0, 32'h4c, 0, 0, 1);
    cyc(0, 0, 32'h0, 0, 0, 0, 0);
    chk("L_stat_br", brc1, 32'd3);
    chk("L_stat_miss", miss1, 32'd2);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pi, pe;
      pi = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      pe = ($urandom_range(0, 3) == 0) ? pi
         : (($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), pi, pe,
          ($urandom_range(0, 1) == 1), $urandom, ($urandom_range(0, 2) == 0));
    end
    cyc(0, 0, 32'h0, 0, 0, 0, 0);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
